// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from page XX00 into OAM at FE00.
// One byte per READ/WRITE pair; a new 0xFF46 write restarts at once.
module oam_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_reg,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'd159;
  localparam logic [7:0] OAM_PAGE = 8'hFE;

  state_t     state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] data;
  logic [7:0] src_page;

  // Echo RAM pages E0-FF alias the work RAM at C0-DF.
  always_comb begin
    src_page = dma_wdata;
    if (dma_wdata >= 8'hE0) begin
      src_page = dma_wdata & 8'hDF;
    end
  end

  assign mem_wdata = data & {8{mem_we}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      page       <= '0;
      data       <= '0;
      dma_reg    <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
    end else if (dma_wr) begin
      dma_reg    <= dma_wdata;
      page       <= src_page;
      idx        <= '0;
      state      <= READ;
      mem_addr   <= {src_page, 8'h00};
      mem_re     <= 1'b1;
      mem_we     <= 1'b0;
      dma_active <= 1'b1;
      dma_done   <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      unique case (state)
        IDLE: begin
          mem_addr   <= '0;
          mem_re     <= 1'b0;
          mem_we     <= 1'b0;
          dma_active <= 1'b0;
        end
        READ: begin
          data       <= mem_rdata;
          state      <= WRITE;
          mem_addr   <= {OAM_PAGE, idx};
          mem_re     <= 1'b0;
          mem_we     <= 1'b1;
          dma_active <= 1'b1;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            dma_active <= 1'b0;
            dma_done   <= 1'b1;
          end else begin
            idx        <= idx + 8'd1;
            state      <= READ;
            mem_addr   <= {page, idx + 8'd1};
            mem_re     <= 1'b1;
            mem_we     <= 1'b0;
            dma_active <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          mem_addr   <= '0;
          mem_re     <= 1'b0;
          mem_we     <= 1'b0;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random stimulus against a cycle-count reference
// model of the 320-cycle copy, plus directed restart/reset cases.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic        dma_wr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_reg;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        dma_active;
  logic        dma_done;

  int n_chk;
  int n_err;

  logic [7:0] mem [65536];

  bit         m_on;
  int         m_n;
  logic [7:0] m_page;
  logic [7:0] m_reg;
  bit         m_done;
  int         done_cnt;

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .dma_wr     (dma_wr),
    .dma_wdata  (dma_wdata),
    .dma_reg    (dma_reg),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .dma_active (dma_active),
    .dma_done   (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? mem[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (dma_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] map_page(logic [7:0] p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

  // Model: a transfer is 320 numbered cycles; odd ones read, even ones write.
  task automatic model_edge(bit wr, logic [7:0] d);
    m_done = 1'b0;
    if (rst) begin
      m_on = 1'b0;
      m_n = 0;
      m_reg = 8'h00;
    end else if (wr) begin
      m_on = 1'b1;
      m_n = 1;
      m_reg = d;
      m_page = map_page(d);
    end else if (m_on) begin
      if (m_n == 320) begin
        m_on = 1'b0;
        m_done = 1'b1;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic check_outputs();
    int i;
    bit rd;
    i = (m_n - 1) / 2;
    rd = (m_n % 2) == 1;
    chk("dma_reg", 32'(dma_reg), 32'(m_reg));
    chk("dma_active", 32'(dma_active), 32'(m_on));
    chk("dma_done", 32'(dma_done), 32'(m_done));
    if (!m_on) begin
      chk("idle_re", 32'(mem_re), 0);
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_addr", 32'(mem_addr), 0);
      chk("idle_wdata", 32'(mem_wdata), 0);
    end else if (rd) begin
      chk("rd_re", 32'(mem_re), 1);
      chk("rd_we", 32'(mem_we), 0);
      chk("rd_addr", 32'(mem_addr), 32'(m_page) * 256 + i);
    end else begin
      chk("wr_re", 32'(mem_re), 0);
      chk("wr_we", 32'(mem_we), 1);
      chk("wr_addr", 32'(mem_addr), 32'hFE00 + i);
      chk("wr_data", 32'(mem_wdata), 32'(mem[32'(m_page) * 256 + i]));
    end
  endtask

  task automatic step(bit wr, logic [7:0] d);
    dma_wr = wr;
    dma_wdata = wr ? d : 8'($urandom);
    @(posedge clk);
    model_edge(wr, d);
    @(negedge clk);
    dma_wr = 1'b0;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) step(1'b0, 8'h00);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_active", 32'(dma_active), 0);
    chk("rst_reg", 32'(dma_reg), 0);
    m_on = 1'b0;
    m_n = 0;
    m_reg = 8'h00;
    m_done = 1'b0;
    run(3);
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    n_chk = 0;
    n_err = 0;
    done_cnt = 0;
    m_on = 1'b0;
    m_n = 0;
    m_reg = 8'h00;
    m_page = 8'h00;
    m_done = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 160; a++) mem[16'hC000 + a] = 8'(a) ^ 8'h5A;
    rst = 1'b1;
    dma_wr = 1'b0;
    dma_wdata = 8'h00;
    #1;
    check_outputs();
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(2);

    // Full copy from C0
    d0 = done_cnt;
    step(1'b1, 8'hC0);
    run(330);
    chk("copy_done_cnt", 32'(done_cnt - d0), 1);
    for (int a = 0; a < 160; a++) begin
      chk("copy_oam", 32'(mem[16'hFE00 + a]), 32'(8'(a) ^ 8'h5A));
    end
    chk("copy_reg", 32'(dma_reg), 32'hC0);

    // Echo page F1 reads D1
    step(1'b1, 8'hF1);
    chk("echo_addr", 32'(mem_addr), 32'hD100);
    run(330);
    chk("echo_reg", 32'(dma_reg), 32'hF1);

    // Restart at idx 50
    d0 = done_cnt;
    step(1'b1, 8'hC0);
    run(100);
    step(1'b1, 8'hD0);
    chk("restart_addr", 32'(mem_addr), 32'hD000);
    run(330);
    chk("restart_done_cnt", 32'(done_cnt - d0), 1);
    for (int a = 0; a < 160; a++) begin
      chk("restart_oam", 32'(mem[16'hFE00 + a]), 32'(mem[16'hD000 + a]));
    end

    // Restart on the final WRITE
    d0 = done_cnt;
    step(1'b1, 8'hC1);
    run(319);
    chk("final_n", 32'(m_n), 320);
    step(1'b1, 8'hC2);
    chk("final_restart_re", 32'(mem_re), 1);
    chk("final_restart_addr", 32'(mem_addr), 32'hC200);
    run(2);
    chk("final_no_done", 32'(done_cnt - d0), 0);
    run(330);
    chk("final_one_done", 32'(done_cnt - d0), 1);

    // Reset at idx 80
    d0 = done_cnt;
    step(1'b1, 8'hC3);
    run(160);
    async_reset();
    run(400);
    chk("rst_no_done", 32'(done_cnt - d0), 0);

    // Random restarts and pages
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 299) == 0), 8'($urandom));
    end
    run(330);

    // Long idle
    d0 = done_cnt;
    run(1000);
    chk("idle_done_cnt", 32'(done_cnt - d0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL provide `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide `dma_wr`, input, 1: one-cycle pulse when the CPU writes control register 0xFF46.
REQ-004 SHALL provide `dma_wdata`, input, 8: byte written to 0xFF46, used as the source page (high address byte).
REQ-005 SHALL provide `dma_reg`, output, 8: last accepted value of 0xFF46, fed back to the control register block.
REQ-006 SHALL provide `mem_addr`, output, 16: DMA bus address.
REQ-007 SHALL provide `mem_re`, output, 1: DMA read strobe.
REQ-008 SHALL provide `mem_we`, output, 1: DMA write strobe.
REQ-009 SHALL provide `mem_rdata`, input, 8: read data, valid in the same cycle as `mem_re` (combinational memory read).
REQ-010 SHALL provide `mem_wdata`, output, 8: DMA write data.
REQ-011 SHALL provide `dma_active`, output, 1: DMA owns the bus; CPU bus accesses are held off while high.
REQ-012 SHALL provide `dma_done`, output, 1: one-cycle pulse on transfer completion.

Function
REQ-013 SHALL implement a state machine with states IDLE, READ and WRITE.
REQ-014 SHALL, on `dma_wr`=1 at a rising edge in any state, latch `dma_wdata` into `dma_reg` and into an internal source page.
REQ-015 SHALL, on the same event, clear the byte index to 0 and enter READ.
REQ-016 SHALL map a source page of 0xE0-0xFF to (page AND 0xDF) for addressing; `dma_reg` SHALL keep the unmapped value.
REQ-017 SHALL, in READ, drive `mem_re`=1, `mem_we`=0 and `mem_addr`={source page, idx}.
REQ-018 SHALL capture `mem_rdata` into a data register at the end of each READ cycle, then enter WRITE.
REQ-019 SHALL, in WRITE, drive `mem_we`=1, `mem_re`=0, `mem_addr`=0xFE00+idx and `mem_wdata`=the captured byte.
REQ-020 SHALL, from WRITE with idx<159, increment idx by 1 and enter READ.
REQ-021 SHALL, from WRITE with idx=159, enter IDLE and assert `dma_done` for exactly the following cycle.
REQ-022 SHALL use an 8-bit idx that never exceeds 159; a full transfer is 160 bytes in exactly 320 cycles.
REQ-023 SHALL drive `dma_active`=1 exactly when the state is READ or WRITE.
REQ-024 SHALL hold `mem_re`, `mem_we`, `mem_addr` and `mem_wdata` at 0 in IDLE.
REQ-025 SHALL handle timing as follows: `dma_wr` sampled at edge k gives READ idx0 in cycle k+1 and WRITE idx159 in cycle k+320; in cycle k+321 `dma_done`=1 and `dma_active`=0.
REQ-026 SHALL handle a restart mid-transfer as follows: the current cycle's strobe completes, and the next cycle is READ idx0 of the new page; no `dma_done` is issued for the aborted transfer.
REQ-027 SHALL, when `dma_wr` coincides with the final WRITE, restart and suppress `dma_done`.
REQ-028 SHALL ignore `dma_wdata` when `dma_wr`=0.

Reset
REQ-029 SHALL, while `rst`=1, immediately force IDLE, idx=0, data register=0, `dma_reg`=0x00, and all outputs to 0.
REQ-030 SHALL, on reset asserted mid-transfer, abort with no further strobes and no `dma_done`; the transfer does not resume after reset release.

Verification
REQ-031 Full copy: memory 0xC000+i = i^0x5A; `dma_wr` with 0xC0 -> 160 writes to 0xFE00..0xFE9F with matching data, alternating re/we, `dma_done` at cycle k+321, `dma_reg`=0xC0.
REQ-032 Echo mapping: `dma_wr` with 0xF1 -> reads from 0xD100..0xD19F; `dma_reg` reads 0xF1.
REQ-033 Restart: `dma_wr` 0xC0, then `dma_wr` 0xD0 at idx=50 -> next cycle READ at 0xD000; exactly one `dma_done`, 320 cycles after the second write; final OAM holds 0xD0 page data.
REQ-034 Restart on final WRITE: `dma_wr` coincides with the idx159 WRITE -> no `dma_done`, and READ idx0 follows immediately.
REQ-035 Reset mid-transfer: `rst` pulsed at idx=80 -> strobes, `dma_active` and `dma_reg` drop to 0 asynchronously and stay 0 until the next `dma_wr`.
REQ-036 Idle check: 1000 cycles with no `dma_wr` -> `mem_re`, `mem_we`, `dma_active` and `dma_done` remain 0.
